fp_div_seq: RTL
===============

FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (valid range 4..11).
REQ-002 SHALL have parameter FRAC_W, default 23, stored fraction width (valid range 4..52); W = 1+EXP_W+FRAC_W.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous and active-high.
REQ-005 SHALL have port start  in  1  request; accepted only on a rising edge where busy=0.
REQ-006 SHALL have port input_a  in  W  IEEE-754-format dividend, sampled on the accepting edge.
REQ-007 SHALL have port input_b  in  W  IEEE-754-format divisor, sampled on the accepting edge.
REQ-008 SHALL have port output_z  out  W  quotient; valid while done=1, held until the next accepted start.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port done  out  1  one-cycle pulse marking output_z/flags valid.
REQ-011 SHALL have port flags  out  5  {invalid, divzero, overflow, underflow, inexact}; same validity as output_z.

Function
REQ-012 SHALL implement the FSM IDLE -> PREP -> DIV -> ROUND -> DONE -> IDLE, plus IDLE -> SPEC -> DONE for special operands.
REQ-013 SHALL, in PREP (1 cycle), normalise subnormal mantissas with a leading-zero count and form the biased exponent difference in EXP_W+2 signed bits.
REQ-014 SHALL, in DIV, run radix-2 restoring division for exactly FRAC_W+3 cycles, one quotient bit per cycle, controlled by an iteration counter; quotient covers hidden bit, FRAC_W bits, guard, round, with sticky = OR of the final remainder.
REQ-015 SHALL pre-shift the dividend mantissa when it is smaller than the divisor mantissa, decrementing the exponent, so the quotient lies in [1,2).
REQ-016 SHALL, in ROUND (1 cycle), right-shift by (1 - exponent) into guard/round/sticky when the exponent is <= 0, apply round-to-nearest-even, and renormalise on mantissa carry-out.
REQ-017 SHALL assert done exactly FRAC_W+6 rising edges after the accepting edge for finite non-zero operands (29 for defaults), and exactly 2 edges after it for special operands.
REQ-018 SHALL take result sign = sign_a XOR sign_b for every non-NaN result.
REQ-019 SHALL return canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0) with invalid=1 for: NaN operand, 0/0, inf/inf; a signalling-NaN input sets invalid, a quiet NaN does not.
REQ-020 SHALL return signed infinity with divzero=1 for finite non-zero / 0.
REQ-021 SHALL return signed infinity with no flags for inf / finite, and signed zero with no flags for 0 / non-zero finite and finite / inf.
REQ-022 SHALL, when the rounded exponent >= all-ones, return signed infinity with overflow=1 and inexact=1.
REQ-023 SHALL set inexact when any of guard, round or sticky is non-zero, and underflow only when the result is tiny (before rounding) and inexact.
REQ-024 SHALL ignore start while busy=1; a start held high in the DONE cycle is not accepted until the following edge in IDLE.
REQ-025 SHALL make done high only in the DONE state; output_z and flags SHALL not change outside the DONE transition.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-operation, force state IDLE, counter 0, busy=0, done=0, output_z=0, flags=0, abandoning any operation.
REQ-027 SHALL accept start on the first rising edge after rst deasserts.

Verification (defaults)
REQ-028 SHALL check 0x40C00000 / 0x40000000 -> output_z=0x40400000, flags=0, done on edge 29, busy high edges 1..29.
REQ-029 SHALL check 0x3F800000 / 0x40400000 -> 0x3EAAAAAB, flags=00001 (inexact).
REQ-030 SHALL check 0x3F800000 / 0x00000000 -> 0x7F800000, flags=01000, done on edge 2; and 0x00000000 / 0x00000000 -> 0x7FC00000, flags=10000.
REQ-031 SHALL check 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, flags=00101; and 0x00800000 / 0x40000000 -> 0x00400000, flags=0.
REQ-032 SHALL check rst pulsed at edge 10 of an operation -> busy=0, done=0, output_z=0 immediately; a second start 0x40C00000 / 0x40000000 issued while busy is ignored; a new start after reset completes normally.
REQ-033 SHALL repeat REQ-028 with EXP_W=5, FRAC_W=10: 0x4600 / 0x4000 -> 0x4200, done on edge 16.

Source files
------------

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider: one quotient bit per cycle (restoring), round-to-nearest-even.
module fp_div_seq #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [EXP_W+FRAC_W:0] input_a,
    input  logic [EXP_W+FRAC_W:0] input_b,
    output logic [EXP_W+FRAC_W:0] output_z,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            flags
);
    localparam int unsigned W    = 1 + EXP_W + FRAC_W;
    localparam int unsigned MW   = FRAC_W + 1;          // mantissa incl. hidden bit
    localparam int unsigned RW   = MW + 1;              // partial remainder
    localparam int unsigned QW   = FRAC_W + 3;          // hidden, fraction, guard, round
    localparam int unsigned EW   = EXP_W + 2;           // signed working exponent
    localparam int unsigned CW   = $clog2(QW + 1);
    localparam int unsigned LZW  = $clog2(MW + 1);
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_DIV, S_ROUND, S_SPEC, S_DONE
    } state_t;

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;
    } cls_t;

    state_t state_q, state_d;

    logic [W-1:0]          a_q, b_q;
    logic [MW-1:0]         mb_q;
    logic [RW-1:0]         rem_q;
    logic [QW-1:0]         q_q;
    logic signed [EW-1:0]  exp_q;
    logic [CW-1:0]         cnt_q;

    // Operand classification for the special-case path.
    function automatic cls_t classify(input logic [W-1:0] x);
        cls_t c;
        logic e_ones, e_zero, f_zero;
        e_ones = &x[W-2:FRAC_W];
        e_zero = ~|x[W-2:FRAC_W];
        f_zero = ~|x[FRAC_W-1:0];
        c.nan  = e_ones & ~f_zero;
        c.snan = e_ones & ~f_zero & ~x[FRAC_W-1];
        c.inf  = e_ones & f_zero;
        c.zero = e_zero & f_zero;
        return c;
    endfunction

    // Leading-zero count of a mantissa (subnormal normalisation).
    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] m);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = int'(MW) - 1; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      n = n + LZW'(1);
            end
        end
        return n;
    endfunction

    cls_t ca_in, cb_in, ca, cb;
    logic in_special, sign;

    assign ca_in      = classify(input_a);
    assign cb_in      = classify(input_b);
    assign in_special = ca_in.nan | ca_in.inf | ca_in.zero | cb_in.nan | cb_in.inf | cb_in.zero;
    assign ca         = classify(a_q);
    assign cb         = classify(b_q);
    assign sign       = a_q[W-1] ^ b_q[W-1];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = in_special ? S_SPEC : S_PREP;
            S_PREP:  state_d = S_DIV;
            S_DIV:   if (cnt_q == CW'(QW - 1)) state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_SPEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Normalise mantissas, form exponent difference, pre-shift so quotient lands in [1,2).
    logic [EXP_W-1:0]     pa_fld, pb_fld;
    logic [MW-1:0]        pa_raw, pb_raw, pa_man, pb_man;
    logic [LZW-1:0]       pa_lz, pb_lz;
    logic signed [EW-1:0] pa_exp, pb_exp, p_diff, p_exp;
    logic                 p_lt;
    logic [RW-1:0]        p_rem;

    always_comb begin
        pa_fld = a_q[W-2:FRAC_W];
        pb_fld = b_q[W-2:FRAC_W];
        pa_raw = {|pa_fld, a_q[FRAC_W-1:0]};
        pb_raw = {|pb_fld, b_q[FRAC_W-1:0]};
        pa_lz  = lzc(pa_raw);
        pb_lz  = lzc(pb_raw);
        pa_man = pa_raw << pa_lz;
        pb_man = pb_raw << pb_lz;
        pa_exp = EW'((pa_fld == '0) ? EXP_W'(1) : pa_fld) - EW'(pa_lz);
        pb_exp = EW'((pb_fld == '0) ? EXP_W'(1) : pb_fld) - EW'(pb_lz);
        p_diff = pa_exp - pb_exp + EW'(BIAS);
        p_lt   = pa_man < pb_man;
        p_rem  = p_lt ? {pa_man, 1'b0} : {1'b0, pa_man};
        p_exp  = p_lt ? p_diff - EW'(1) : p_diff;
    end

    // One restoring-division step.
    logic          d_ge;
    logic [RW-1:0] d_sub, d_rem;

    always_comb begin
        d_ge  = rem_q >= RW'(mb_q);
        d_sub = rem_q - (d_ge ? RW'(mb_q) : RW'(0));
        d_rem = d_sub << 1;
    end

    // Denormalise tiny results, round to nearest even, pack.
    logic                 r_tiny, r_g, r_r, r_st, r_lost, r_up, r_inexact;
    int                   r_sh;
    logic [QW-1:0]        r_shifted;
    logic [MW-1:0]        r_m, r_mf;
    logic [RW-1:0]        r_sum;
    logic signed [EW-1:0] r_e, r_ef;
    logic [EXP_W-1:0]     r_efld;
    logic [W-1:0]         round_z;
    logic [4:0]           round_f;

    always_comb begin
        r_tiny = exp_q[EW-1] | (exp_q == '0);
        r_sh   = 0;
        if (r_tiny) begin
            r_sh = 1 - int'(exp_q);
            if (r_sh > int'(QW)) r_sh = int'(QW);
        end
        r_shifted = q_q >> r_sh;
        r_lost    = |(q_q & ~({QW{1'b1}} << r_sh));
        r_m       = r_shifted[QW-1:2];
        r_g       = r_shifted[1];
        r_r       = r_shifted[0];
        r_st      = (|rem_q) | r_lost;
        r_up      = r_g & (r_r | r_st | r_m[0]);
        r_inexact = r_g | r_r | r_st;
        r_sum     = {1'b0, r_m} + RW'(r_up);
        r_e       = r_tiny ? EW'(1) : exp_q;
        if (r_sum[MW]) begin
            r_mf = r_sum[MW:1];
            r_ef = r_e + EW'(1);
        end else begin
            r_mf = r_sum[MW-1:0];
            r_ef = r_e;
        end
        r_efld = r_mf[FRAC_W] ? r_ef[EXP_W-1:0] : {EXP_W{1'b0}};
        if (r_ef >= EXP_MAX) begin
            round_z = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            round_f = 5'b00101;
        end else begin
            round_z = {sign, r_efld, r_mf[FRAC_W-1:0]};
            round_f = {2'b00, 1'b0, r_tiny & r_inexact, r_inexact};
        end
    end

    // Results for NaN, infinity and zero operands.
    logic [W-1:0] spec_z;
    logic [4:0]   spec_f;

    always_comb begin
        spec_z = '0;
        spec_f = '0;
        if (ca.nan | cb.nan) begin
            spec_z    = QNAN;
            spec_f[4] = ca.snan | cb.snan;
        end else if ((ca.zero & cb.zero) | (ca.inf & cb.inf)) begin
            spec_z    = QNAN;
            spec_f[4] = 1'b1;
        end else if (ca.inf) begin
            spec_z = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (cb.zero) begin
            spec_z    = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            spec_f[3] = 1'b1;
        end else begin
            spec_z = {sign, {(W-1){1'b0}}};
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            mb_q     <= '0;
            rem_q    <= '0;
            q_q      <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            output_z <= '0;
            flags    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (state_d != S_IDLE);
            done <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q <= input_a;
                        b_q <= input_b;
                    end
                end
                S_PREP: begin
                    mb_q  <= pb_man;
                    rem_q <= p_rem;
                    exp_q <= p_exp;
                    q_q   <= '0;
                    cnt_q <= '0;
                end
                S_DIV: begin
                    rem_q <= d_rem;
                    q_q   <= {q_q[QW-2:0], d_ge};
                    cnt_q <= cnt_q + CW'(1);
                end
                S_ROUND: begin
                    output_z <= round_z;
                    flags    <= round_f;
                    cnt_q    <= '0;
                end
                S_SPEC: begin
                    output_z <= spec_z;
                    flags    <= spec_f;
                end
                default: ;
            endcase
        end
    end
endmodule
